// File: rtl/envelope_vca.sv
// Envelope VCA: signed sample x unsigned fixed-point gain, round-half-up, saturate.
// Define VCA_SLEW_EN to rate-limit gain changes to SLEW_STEP per accepted sample.
module envelope_vca #(
  parameter int SAMPLE_W  = 24,
  parameter int AMP_W     = 31,
  parameter int AMP_FRAC  = 16,
  parameter int SLEW_STEP = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid_in,
  input  logic        [AMP_W-1:0]    amplitude,
  input  logic                       mute,
  input  logic                       clip_clr,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid_out,
  output logic                       clip,
  output logic                       clip_sticky
);

  localparam int STAGES = 2;
  localparam int P_W    = SAMPLE_W + AMP_W + 1;

  localparam logic signed [P_W-1:0] HALF  =
    {{(P_W-AMP_FRAC){1'b0}}, 1'b1, {(AMP_FRAC-1){1'b0}}};
  localparam logic signed [P_W-1:0] R_MAX =
    {{(P_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [P_W-1:0] R_MIN =
    {{(P_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  logic [STAGES:0]             vld_pipe;
  logic [AMP_W-1:0]            g, tgt, g_nxt;
  logic signed [SAMPLE_W-1:0]  s0;
  logic signed [P_W-1:0]       s0_x, g_x, p, p_rnd, r;
  logic                        sat_hi, sat_lo;

  // Target gain and next gain (slew-limited when enabled)
  always_comb begin
    tgt   = mute ? '0 : amplitude;
    g_nxt = tgt;
`ifdef VCA_SLEW_EN
    if (tgt > g && (tgt - g) > AMP_W'(SLEW_STEP))
      g_nxt = g + AMP_W'(SLEW_STEP);
    else if (tgt < g && (g - tgt) > AMP_W'(SLEW_STEP))
      g_nxt = g - AMP_W'(SLEW_STEP);
`endif
  end

`ifndef VCA_SLEW_EN
  localparam int unused_slew_step = SLEW_STEP;
`endif

  // Operands widened to the full product width; gain is zero-extended
  assign s0_x = P_W'(s0);
  assign g_x  = {{(P_W-AMP_W){1'b0}}, g};

  always_comb begin
    p_rnd  = p + HALF;
    r      = p_rnd >>> AMP_FRAC;
    sat_hi = r > R_MAX;
    sat_lo = r < R_MIN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe    <= '0;
      g           <= '0;
      s0          <= '0;
      p           <= '0;
      sample_out  <= '0;
      clip        <= 1'b0;
      clip_sticky <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], sample_valid_in};
      // Stage 0: capture sample and advance gain; the sample sees the new gain
      if (sample_valid_in) begin
        s0 <= sample_in;
        g  <= g_nxt;
      end
      // Stage 1: full-width product
      if (vld_pipe[0])
        p <= s0_x * g_x;
      // Stage 2: round, saturate, register output
      if (vld_pipe[1]) begin
        if (sat_hi)      sample_out <= {1'b0, {(SAMPLE_W-1){1'b1}}};
        else if (sat_lo) sample_out <= {1'b1, {(SAMPLE_W-1){1'b0}}};
        else             sample_out <= r[SAMPLE_W-1:0];
      end
      clip        <= vld_pipe[1] & (sat_hi | sat_lo);
      // Set wins over clear
      clip_sticky <= (vld_pipe[1] & (sat_hi | sat_lo)) | (clip_sticky & ~clip_clr);
    end
  end

  assign sample_valid_out = vld_pipe[STAGES];

endmodule

// File: tb/tb_envelope_vca.sv
// Scoreboard bench for envelope_vca; follows VCA_SLEW_EN the same way the design does.
module tb_envelope_vca;

  localparam int SW = 24;
  localparam int AW = 31;
  localparam longint SLEW = 64;
`ifdef VCA_SLEW_EN
  localparam int SETTLE = 4200;
  localparam int N_RAMP = 1030;
`else
  localparam int SETTLE = 2;
  localparam int N_RAMP = 8;
`endif

  logic                 clk = 0;
  logic                 reset = 0;
  logic signed [SW-1:0] sample_in = '0;
  logic                 sample_valid_in = 0;
  logic [AW-1:0]        amplitude = '0;
  logic                 mute = 0;
  logic                 clip_clr = 0;
  logic signed [SW-1:0] sample_out;
  logic                 sample_valid_out;
  logic                 clip;
  logic                 clip_sticky;

  envelope_vca dut (
    .clk(clk), .reset(reset),
    .sample_in(sample_in), .sample_valid_in(sample_valid_in),
    .amplitude(amplitude), .mute(mute), .clip_clr(clip_clr),
    .sample_out(sample_out), .sample_valid_out(sample_valid_out),
    .clip(clip), .clip_sticky(clip_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint d;
    bit     c;
    int     cyc;
  } exp_t;

  exp_t   sb[$];
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_err = 0;
  longint gm = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive one strobe, update the reference gain, push the expected result
  task automatic send(input longint s, input longint amp, input bit m);
    exp_t   e;
    longint t, p, r;
    sample_in       = SW'(s);
    amplitude       = AW'(amp);
    mute            = m;
    sample_valid_in = 1;
    t = m ? 0 : amp;
`ifdef VCA_SLEW_EN
    if (t > gm + SLEW)      gm = gm + SLEW;
    else if (t < gm - SLEW) gm = gm - SLEW;
    else                    gm = t;
`else
    gm = t;
`endif
    p = s * gm;
    r = (p + 32768) >>> 16;
    e.c = 0;
    if (r > 8388607)       begin r = 8388607;  e.c = 1; end
    else if (r < -8388608) begin r = -8388608; e.c = 1; end
    e.d   = r;
    e.cyc = cyc + 3;
    sb.push_back(e);
    @(posedge clk); #1;
    sample_valid_in = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle(input longint amp);
    for (int i = 0; i < SETTLE; i++) send(0, amp, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    chk("drain", sb.size(), 0);
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("rst_vld", sample_valid_out, 0);
    end else if (sample_valid_out) begin
      if (sb.size() == 0) begin
        chk("unexp_vld", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc, e.cyc);
        chk("data", longint'(sample_out), e.d);
        chk("clip", clip, e.c);
      end
    end else begin
      chk("clip_idle", clip, 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, then reset with two samples in flight
    idle(3);
    chk("rst_out", longint'(sample_out), 0);
    chk("rst_vld0", sample_valid_out, 0);
    chk("rst_stky", clip_sticky, 0);
    reset = 1;
    idle(4);
    send(100000, 65536, 0);
    idle(4);
    send(300, 65536, 0);
    send(400, 65536, 0);
    reset = 0;
    sb.delete();
    gm = 0;
    #1;
    chk("mid_rst_out", longint'(sample_out), 0);
    chk("mid_rst_vld", sample_valid_out, 0);
    chk("mid_rst_stky", clip_sticky, 0);
    idle(2);
    reset = 1;
    idle(6);

    // 4: gain ramp up from zero, then down
    for (int i = 0; i < N_RAMP; i++) send(65536, 65536, 0);
    for (int i = 0; i < N_RAMP; i++) send(65536, 0, 0);
    drain();

    // 2: unity and half gain, rounding edges
    settle(65536);
    send(1000, 65536, 0);
    settle(32768);
    send(-1001, 32768, 0);
    send(1, 32768, 0);
    send(-1, 32768, 0);
    drain();

    // 3: saturation and sticky flag
    settle(262144);
    send(4194304, 262144, 0);
    send(-4194304, 262144, 0);
    send(2097151, 262144, 0);
    drain();
    chk("stky_set", clip_sticky, 1);
    clip_clr = 1;
    idle(1);
    clip_clr = 0;
    chk("stky_clr", clip_sticky, 0);
    send(4194304, 262144, 0);
    idle(1);
    clip_clr = 1;
    idle(1);
    clip_clr = 0;
    chk("stky_setwin", clip_sticky, 1);
    clip_clr = 1;
    idle(1);
    clip_clr = 0;
    chk("stky_clr2", clip_sticky, 0);
    drain();

    // 5: mute forces zero (negative sample must not become -1), unmute restores
    settle(65536);
    for (int i = 0; i < SETTLE; i++) send(0, 65536, 1);
    send(-1001, 65536, 1);
    send(5000, 65536, 1);
    settle(65536);
    send(5000, 65536, 0);
    drain();

    // 6: back-to-back burst, then spaced strobes with amplitude wiggled in gaps
    for (int i = 0; i < 8; i++) send(i * 1000 - 3000, 40000, 0);
    for (int i = 0; i < 4; i++) begin
      send(7000 - i * 4000, 40000, 0);
      amplitude = AW'(12345 + i);
      idle(5);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/envelope_vca.md
Name: envelope_vca

Overview:
Voltage-controlled-amplifier stage directly downstream of the ADSR envelope generator. It multiplies each signed audio sample from the oscillator path by the envelope's current amplitude, a fixed-point gain. It then rounds and saturates the product back to sample width and hands the result to the audio codec output path. A per-sample slew limiter on the gain suppresses zipper noise when the envelope steps at its millisecond rate.

Parameters:
SAMPLE_W, 24, width of signed two's-complement audio samples in and out
AMP_W, 31, width of unsigned amplitude/gain input (matches envelope cur_amplitude)
AMP_FRAC, 16, fractional bits of gain; gain 2^AMP_FRAC = unity (65536)
SLEW_STEP, 64, max gain change per accepted sample (slew limiter only)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
sample_in  input  SAMPLE_W  signed audio sample from oscillator/mixer
sample_valid_in  input  1  one-cycle strobe; sample_in is valid this cycle
amplitude  input  AMP_W  target gain, driven by envelope cur_amplitude
mute  input  1  level; forces target gain to 0
clip_clr  input  1  clears sticky clip flag
sample_out  output  SAMPLE_W  signed scaled sample
sample_valid_out  output  1  one-cycle strobe; sample_out valid
clip  output  1  pulses with sample_valid_out when that sample saturated
clip_sticky  output  1  set on any clip, held until clip_clr or reset

Behaviour:
- Reset (reset=0, asynchronous): gain register g=0; all pipeline data=0; all valid bits=0. Outputs sample_out=0, sample_valid_out=0, clip=0, clip_sticky=0. Reset mid-pipeline discards in-flight samples; no valid_out is produced for them.
- Target T = mute ? 0 : amplitude, sampled only in cycles with sample_valid_in=1.
- Stage 0 (cycle of sample_valid_in=1): register sample_in into s0 and update g:
  - if T > g and T-g > SLEW_STEP: g <= g+SLEW_STEP
  - else if T < g and g-T > SLEW_STEP: g <= g-SLEW_STEP
  - else g <= T
  - g is unchanged in cycles with sample_valid_in=0. The sample uses the updated g, so the first sample after reset with T=65536 uses g=64.
- Stage 1: p = s0 * g, signed x unsigned (gain zero-extended), full-width SAMPLE_W+AMP_W+1-bit product, registered.
- Stage 2: r = (p + 2^(AMP_FRAC-1)) >>> AMP_FRAC, arithmetic shift, round half toward +inf.
  - if r > 2^(SAMPLE_W-1)-1: sample_out = 0x7FFFFF, clip=1
  - if r < -2^(SAMPLE_W-1): sample_out = 0x800000, clip=1
  - else sample_out = r[SAMPLE_W-1:0], clip=0
- Latency: sample_valid_out asserts exactly 3 cycles after sample_valid_in, for 1 cycle.
- Throughput: 1 sample/cycle. Back-to-back strobes are fully pipelined, with no stalls or drops.
- sample_out holds its last value between strobes. clip is 0 whenever sample_valid_out=0.
- clip_sticky: set when clip=1. clip_clr=1 clears it. If set and clear coincide in the same cycle, set wins.
- Gain 0 yields sample_out=0 exactly; a negative sample does not round to -1.
- amplitude changing between strobes has no effect until the next strobe.

Optional Feature:
VCA_SLEW_EN
- Defined: slew limiter as above.
- Undefined: g <= T directly on every strobe, with no SLEW_STEP logic synthesized. SLEW_STEP is ignored; latency and saturation are unchanged.

Test Plan:
1. Reset release, no strobes, then assert reset mid-stream with 2 samples in flight -> sample_out=0, sample_valid_out=0, clip_sticky=0, no valid_out for the discarded samples.
2. Slew off (or gain settled): amplitude=65536, sample_in=1000, strobe -> 3 cycles later sample_out=1000, clip=0. Same with amplitude=32768, sample_in=-1001 -> -500.
3. amplitude=262144 (4x), sample_in=4194304 -> sample_out=0x7FFFFF, clip=1, clip_sticky=1. Then sample_in=-4194304 -> 0x800000. clip_clr with no new clip -> clip_sticky=0.
4. VCA_SLEW_EN defined, g=0, amplitude=65536, sample_in=65536 every cycle -> outputs 64, 128, 192, ... and gain reaches 65536 on the 1024th strobe. Step amplitude down to 0 -> gain falls by 64 per strobe.
5. mute=1 with amplitude=65536, slew off -> sample_out=0 on the next output. Drop mute -> unity restored.
6. Strobes on 8 consecutive cycles, then gaps of 5 cycles -> 8 consecutive valid_out pulses starting 3 cycles after the first strobe, in order. g is unchanged during the gaps.
